lcd_timing_pattern_gen: RTL and testbench
=========================================

Name: lcd_timing_pattern_gen

Overview:
Parametrised RGB565 LCD timing generator with a built-in test-pattern source. It replaces the fixed-resolution VGA-style timing module.
- Derives a pixel-clock enable from CLK_SYS.
- Produces DE/HSYNC/VSYNC with configurable porches and sync polarity.
- Drives one of four selectable patterns.
- Exposes frame-start and frame-count status for LED/debug logic in the top level.

Parameters:
H_ACTIVE, 800, active pixels per line (multiple of 8)
H_FP, 40, horizontal front porch (pixel ticks)
H_SYNC, 48, HSYNC pulse width (pixel ticks)
H_BP, 40, horizontal back porch (pixel ticks)
V_ACTIVE, 480, active lines per frame
V_FP, 13, vertical front porch (lines)
V_SYNC, 3, VSYNC pulse width (lines)
V_BP, 29, vertical back porch (lines)
PIX_DIV, 1, CLK_SYS cycles per pixel tick (>=1)
HS_POL, 0, HSYNC active level (0 = active-low)
VS_POL, 0, VSYNC active level (0 = active-low)
CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels
CNT_W, 12, width of h/v counters (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
CLK_SYS  in  1  system clock
rst  in  1  asynchronous active-low reset
mode  in  2  pattern select: 0 colour bars, 1 gradient, 2 checkerboard, 3 solid
solid_rgb  in  16  {R[4:0],G[5:0],B[4:0]} colour for mode 3
pix_ce  out  1  pixel-tick enable, one CLK_SYS cycle wide
LCD_DE  out  1  data enable
LCD_HSYNC  out  1  horizontal sync
LCD_VSYNC  out  1  vertical sync
LCD_R  out  5  red
LCD_G  out  6  green
LCD_B  out  5  blue
frame_start  out  1  one-CLK_SYS pulse at frame wrap
frame_cnt  out  16  frames completed since reset, wraps 0xFFFF->0

Behaviour:
- Reset and clocking: reset rst, asynchronous, active-low; clock CLK_SYS. All state is in the CLK_SYS domain.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset values (while rst=0):
  - div counter, h_cnt, v_cnt = 0
  - pix_ce = 0, LCD_DE = 0
  - LCD_HSYNC = ~HS_POL, LCD_VSYNC = ~VS_POL
  - RGB = 0, frame_start = 0, frame_cnt = 0
  - latched mode = 0
- Pixel enable:
  - div counter counts 0..PIX_DIV-1; pix_ce = 1 when it equals PIX_DIV-1.
  - PIX_DIV=1 gives pix_ce high every cycle after the first post-reset edge.
  - First pix_ce occurs on the PIX_DIV-th CLK_SYS edge after reset release.
- Counters (advance only on pix_ce):
  - h_cnt counts 0..H_TOTAL-1 then wraps to 0.
  - v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
  - Line order: active [0,H_ACTIVE), front porch, sync, back porch. Frame order uses the same sequence with lines.
- Timing outputs: registered on pix_ce, with one pixel-tick latency from counter state.
  - DE = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE)
  - HSYNC = HS_POL while h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL
  - VSYNC = VS_POL while v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) for whole lines, else ~VS_POL
  - All outputs hold value between pix_ce cycles.
- Mode latching: mode is latched only on the pix_ce where counters wrap to (0,0). A mid-frame mode change takes effect from the next frame; there is no tearing.
- Patterns (x = h_cnt, y = v_cnt, active region only):
  - Mode 0: 8 bars, bar = x/(H_ACTIVE/8). Order: white, yellow, cyan, green, magenta, red, blue, black. Components are full-scale (1F/3F/1F) or 0.
  - Mode 1: R = x[7:3], G = x[7:2], B = y[7:3].
  - Mode 2: white if x[CHK_LOG2]^y[CHK_LOG2], else black.
  - Mode 3: solid_rgb, sampled every pixel tick.
  - RGB forced to 0 whenever the registered DE is 0.
- Frame status:
  - frame_start = 1 for exactly one CLK_SYS cycle: the pix_ce cycle in which (h_cnt,v_cnt) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0).
  - frame_cnt increments in that same cycle.
  - No frame_start is generated at reset release.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). After release, timing restarts at (0,0).

Test Plan:
Sim params for all scenarios: H_ACTIVE 16, H_FP 2, H_SYNC 3, H_BP 3, V_ACTIVE 4, V_FP 1, V_SYNC 2, V_BP 1, PIX_DIV 2, CHK_LOG2 2, default polarities.

1. Frame timing, mode 3, solid_rgb=16'hF800:
   - pix_ce toggles every 2nd CLK_SYS cycle.
   - DE high for 16 ticks on each of 4 lines per frame.
   - HSYNC low for 3 ticks starting 18 ticks after DE rise.
   - VSYNC low for 2 full lines (48 ticks).
   - frame_start period = 384 CLK_SYS cycles; frame_cnt = 3 after 3 pulses.
   - During DE: R=1F, G=0, B=0. Outside DE: RGB = 0.
2. Colour bars, mode 0:
   - x=0,1 give R/G/B = 1F/3F/1F; x=2,3 give 1F/3F/00; x=10,11 give 1F/00/00; x=14,15 give 0/0/0.
3. Checkerboard, mode 2:
   - line 0: x=0..3 black, x=4..7 white.
   - line 1 identical to line 0 (squares are 4 lines tall).
4. Mode switch mid-frame:
   - Change mode 3->0 at v_cnt=1.
   - Rest of frame stays solid; bars appear from first DE of the next frame.
5. Reset mid-frame:
   - Drop rst at v_cnt=2, h_cnt=5 → DE=0, HSYNC=VSYNC=1, RGB=0, frame_cnt=0 without waiting for a clock edge.
   - After release, first DE rises one pixel tick after the first pix_ce.
6. Polarity and frame_cnt wrap:
   - HS_POL=1, VS_POL=1 → sync pulses high with identical positions.
   - Force frame_cnt to 0xFFFF → next frame_start wraps it to 0.

Source files
------------

// File: rtl/lcd_timing_pattern_gen.sv
// RGB565 LCD timing generator with a selectable built-in test pattern.
// DE/HSYNC/VSYNC/RGB are registered one pixel tick after the h/v counter state.
module lcd_timing_pattern_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int PIX_DIV  = 1,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CHK_LOG2 = 5,
  parameter int CNT_W    = 12
) (
  input  logic        CLK_SYS,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic        pix_ce,
  output logic        LCD_DE,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON    = 1'(HS_POL);
  localparam logic             VS_ON    = 1'(VS_POL);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [1:0]       mode_q;
  logic             h_last, v_last, wrap, de_n, hs_act, vs_act, chk;
  logic [2:0]       bar;
  logic [15:0]      pat;

  // pix_ce is registered from the old divider value so the first tick lands
  // on the PIX_DIV-th edge after reset release.
  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else begin
      pix_ce <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  always_comb begin
    h_last = (h_cnt == H_LAST);
    v_last = (v_cnt == V_LAST);
    wrap   = h_last && v_last;
    de_n   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    bar = '0;
    for (int i = 1; i < 8; i++)
      if (h_cnt >= CNT_W'(i * BAR_W)) bar = 3'(i);
    chk = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];
    pat = '0;
    // Bar order white..black maps to R=~bar[1], G=~bar[2], B=~bar[0].
    case (mode_q)
      2'd0:    pat = {{5{~bar[1]}}, {6{~bar[2]}}, {5{~bar[0]}}};
      2'd1:    pat = {5'(h_cnt >> 3), 6'(h_cnt >> 2), 5'(v_cnt >> 3)};
      2'd2:    pat = {16{chk}};
      default: pat = solid_rgb;
    endcase
  end

  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_q      <= 2'd0;
      LCD_DE      <= 1'b0;
      LCD_HSYNC   <= ~HS_ON;
      LCD_VSYNC   <= ~VS_ON;
      LCD_R       <= '0;
      LCD_G       <= '0;
      LCD_B       <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= pix_ce && wrap;
      if (pix_ce) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        LCD_DE    <= de_n;
        LCD_HSYNC <= hs_act ? HS_ON : ~HS_ON;
        LCD_VSYNC <= vs_act ? VS_ON : ~VS_ON;
        LCD_R     <= de_n ? pat[15:11] : '0;
        LCD_G     <= de_n ? pat[10:5]  : '0;
        LCD_B     <= de_n ? pat[4:0]   : '0;
        // New mode only takes effect at the frame boundary to avoid tearing.
        if (wrap) begin
          mode_q    <= mode;
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Directed bench: small 24x8 raster, PIX_DIV=2; table of (mode,x,y) -> expected outputs.
module tb_lcd_timing_pattern_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [15:0] solid;
  logic        pix_ce, de, hs, vs, fs;
  logic [4:0]  r, b;
  logic [5:0]  g;
  logic [15:0] fc;
  logic        p_ce, p_de, p_hs, p_vs, p_fs;
  logic [4:0]  p_r, p_b;
  logic [5:0]  p_g;
  logic [15:0] p_fc;

  always #5 clk = ~clk;

  lcd_timing_pattern_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(2), .CHK_LOG2(2)) dut (
    .CLK_SYS(clk), .rst(rst), .mode(mode), .solid_rgb(solid), .pix_ce(pix_ce),
    .LCD_DE(de), .LCD_HSYNC(hs), .LCD_VSYNC(vs), .LCD_R(r), .LCD_G(g), .LCD_B(b),
    .frame_start(fs), .frame_cnt(fc));

  lcd_timing_pattern_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(2), .CHK_LOG2(2),
    .HS_POL(1), .VS_POL(1)) dut_p (
    .CLK_SYS(clk), .rst(rst), .mode(mode), .solid_rgb(solid), .pix_ce(p_ce),
    .LCD_DE(p_de), .LCD_HSYNC(p_hs), .LCD_VSYNC(p_vs), .LCD_R(p_r), .LCD_G(p_g), .LCD_B(p_b),
    .frame_start(p_fs), .frame_cnt(p_fc));

  typedef struct {
    logic [1:0]  m;
    int          x;
    int          y;
    logic        de, hs, vs;
    logic [15:0] rgb;
  } vec_t;

  vec_t tbl[$];
  int errors = 0, checks = 0, exp_fc = 0, cyc = 0, t0 = 0, pn = 0, x = 0, y = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endfunction

  function automatic void add(logic [1:0] m, int xx, int yy, logic d, logic h, logic v, logic [15:0] c);
    vec_t e;
    e.m = m; e.x = xx; e.y = yy; e.de = d; e.hs = h; e.vs = v; e.rgb = c;
    tbl.push_back(e);
  endfunction

  // Leaves the bench at the negedge where outputs reflect the next pixel tick.
  task automatic next_pix();
    int k = 0;
    @(negedge clk);
    while (!pix_ce && k < 8) begin @(negedge clk); k++; end
    if (!pix_ce) chk("pix_ce timeout", 0, 1);
    @(negedge clk);
    pn++;
  endtask

  task automatic wait_frame();
    int k = 0;
    @(negedge clk);
    while (!fs && k < 1000) begin @(negedge clk); k++; end
    exp_fc++;
    chk("frame_start seen", fs, 1);
    chk("frame_cnt", fc, exp_fc & 16'hFFFF);
    t0 = cyc;
    pn = -1;
  endtask

  task automatic apply(input vec_t v);
    string t;
    t = $sformatf("m%0d(%0d,%0d)", v.m, v.x, v.y);
    chk({t, " de"}, de, v.de);
    chk({t, " hsync"}, hs, v.hs);
    chk({t, " vsync"}, vs, v.vs);
    chk({t, " rgb"}, {r, g, b}, v.rgb);
    chk({t, " hsync_pol1"}, p_hs, !v.hs);
    chk({t, " vsync_pol1"}, p_vs, !v.vs);
  endtask

  task automatic check_frame(input logic [1:0] m, input logic [15:0] s);
    int nde = 0, nhs = 0, nvs = 0, nhp = 0;
    mode = m; solid = s;
    wait_frame();
    for (int n = 0; n < 192; n++) begin
      next_pix();
      x = pn % 24; y = pn / 24;
      nde += int'(de); nhs += int'(!hs); nvs += int'(!vs); nhp += int'(p_hs);
      foreach (tbl[i])
        if (tbl[i].m == m && tbl[i].x == x && tbl[i].y == y) apply(tbl[i]);
    end
    chk($sformatf("m%0d wrap frame_start", m), fs, 1);
    chk($sformatf("m%0d frame period", m), cyc - t0, 384);
    exp_fc++;
    chk($sformatf("m%0d frame_cnt", m), fc, exp_fc & 16'hFFFF);
    chk($sformatf("m%0d de ticks", m), nde, 64);
    chk($sformatf("m%0d hsync low ticks", m), nhs, 24);
    chk($sformatf("m%0d vsync low ticks", m), nvs, 48);
    chk($sformatf("m%0d hsync_pol1 high ticks", m), nhp, 24);
  endtask

  task automatic reset_checks(input string t);
    chk({t, " de"}, de, 0);
    chk({t, " hsync"}, hs, 1);
    chk({t, " vsync"}, vs, 1);
    chk({t, " rgb"}, {r, g, b}, 0);
    chk({t, " pix_ce"}, pix_ce, 0);
    chk({t, " frame_start"}, fs, 0);
    chk({t, " frame_cnt"}, fc, 0);
    chk({t, " hsync_pol1"}, p_hs, 0);
    chk({t, " vsync_pol1"}, p_vs, 0);
  endtask

  task automatic release_seq();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); chk("rel e1 pix_ce", pix_ce, 0); chk("rel e1 de", de, 0);
    @(negedge clk); chk("rel e2 pix_ce", pix_ce, 1); chk("rel e2 de", de, 0);
    @(negedge clk); chk("rel e3 pix_ce", pix_ce, 0); chk("rel e3 de", de, 1);
    chk("rel mode0 bars white", {r, g, b}, 16'hFFFF);
    @(negedge clk); chk("rel e4 pix_ce", pix_ce, 1); chk("rel frame_start", fs, 0);
    exp_fc = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // mode 3 solid red: active/porch/sync positions
    add(3, 0, 0, 1, 1, 1, 16'hF800);  add(3, 15, 0, 1, 1, 1, 16'hF800);
    add(3, 16, 0, 0, 1, 1, 16'h0000); add(3, 17, 0, 0, 1, 1, 16'h0000);
    add(3, 18, 0, 0, 0, 1, 16'h0000); add(3, 20, 0, 0, 0, 1, 16'h0000);
    add(3, 21, 0, 0, 1, 1, 16'h0000); add(3, 5, 3, 1, 1, 1, 16'hF800);
    add(3, 23, 3, 0, 1, 1, 16'h0000); add(3, 8, 4, 0, 1, 1, 16'h0000);
    add(3, 0, 4, 0, 1, 1, 16'h0000);  add(3, 0, 5, 0, 1, 0, 16'h0000);
    add(3, 19, 5, 0, 0, 0, 16'h0000); add(3, 23, 6, 0, 1, 0, 16'h0000);
    add(3, 0, 7, 0, 1, 1, 16'h0000);
    // mode 0 colour bars, 2 pixels each
    add(0, 0, 0, 1, 1, 1, 16'hFFFF);  add(0, 1, 0, 1, 1, 1, 16'hFFFF);
    add(0, 2, 0, 1, 1, 1, 16'hFFE0);  add(0, 3, 0, 1, 1, 1, 16'hFFE0);
    add(0, 4, 1, 1, 1, 1, 16'h07FF);  add(0, 7, 1, 1, 1, 1, 16'h07E0);
    add(0, 8, 2, 1, 1, 1, 16'hF81F);  add(0, 10, 0, 1, 1, 1, 16'hF800);
    add(0, 11, 0, 1, 1, 1, 16'hF800); add(0, 12, 3, 1, 1, 1, 16'h001F);
    add(0, 14, 0, 1, 1, 1, 16'h0000); add(0, 15, 0, 1, 1, 1, 16'h0000);
    add(0, 16, 0, 0, 1, 1, 16'h0000);
    // mode 2 checkerboard, 4x4 squares
    add(2, 0, 0, 1, 1, 1, 16'h0000);  add(2, 3, 0, 1, 1, 1, 16'h0000);
    add(2, 4, 0, 1, 1, 1, 16'hFFFF);  add(2, 7, 0, 1, 1, 1, 16'hFFFF);
    add(2, 8, 0, 1, 1, 1, 16'h0000);  add(2, 0, 1, 1, 1, 1, 16'h0000);
    add(2, 4, 1, 1, 1, 1, 16'hFFFF);  add(2, 7, 1, 1, 1, 1, 16'hFFFF);
    add(2, 8, 2, 1, 1, 1, 16'h0000);  add(2, 12, 3, 1, 1, 1, 16'hFFFF);
    // mode 1 gradient
    add(1, 3, 1, 1, 1, 1, 16'h0000);  add(1, 4, 2, 1, 1, 1, 16'h0020);
    add(1, 8, 0, 1, 1, 1, 16'h0840);  add(1, 12, 0, 1, 1, 1, 16'h0860);
    add(1, 15, 3, 1, 1, 1, 16'h0860);

    rst = 1'b0; mode = 2'd3; solid = 16'hF800;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    release_seq();

    check_frame(2'd3, 16'hF800);
    check_frame(2'd0, 16'hF800);
    check_frame(2'd2, 16'hF800);
    check_frame(2'd1, 16'hF800);

    // mid-frame mode change: current frame stays solid, bars next frame
    mode = 2'd3; solid = 16'hF800;
    wait_frame();
    while (pn < 24) next_pix();
    chk("switch (0,1) solid", {r, g, b}, 16'hF800);
    mode = 2'd0;
    while (pn < 48) next_pix();
    chk("switch (0,2) still solid", {r, g, b}, 16'hF800);
    while (pn < 87) next_pix();
    chk("switch (15,3) still solid", {r, g, b}, 16'hF800);
    while (pn < 191) next_pix();
    chk("switch wrap frame_start", fs, 1);
    exp_fc++;
    chk("switch frame_cnt", fc, exp_fc);
    next_pix();
    chk("switch next (0,0) white", {r, g, b}, 16'hFFFF);
    while (pn < 196) next_pix();
    chk("switch next (4,0) cyan", {r, g, b}, 16'h07FF);

    // frame_cnt wrap 0xFFFF -> 0
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    if (fc == 16'hFFFF) exp_fc = 16'hFFFF;
    else begin
      $display("note: forced frame_cnt not retained, wrap check skipped");
      exp_fc = int'(fc);
    end
    wait_frame();
    @(negedge clk);
    chk("frame_start one cycle", fs, 0);
    @(negedge clk);
    pn = 0;

    // asynchronous reset mid-frame at (5,2)
    while (pn < 53) next_pix();
    chk("pre-reset (5,2) de", de, 1);
    chk("pre-reset (5,2) cyan", {r, g, b}, 16'h07FF);
    #2 rst = 1'b0;
    #1 reset_checks("async reset");
    repeat (3) @(negedge clk);
    reset_checks("held reset");
    release_seq();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
